// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - Register byte offsets inside the 16-byte window.
//   - STATUS register bit positions.
//   - Transmit FSM state encoding.
package uart_pkg;

  localparam logic [3:0] TXDATA_OFS  = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] BAUDDIV_OFS = 4'h8;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes waiting for transmission.
// Ports:
//   clk, reset    clock, asynchronous active-high reset (pointers/count only)
//   push, din     write strobe and data; ignored while full
//   pop, dout     read strobe and head-of-queue data; ignored while empty
//   full, empty   occupancy flags, judged on the count at the start of the cycle
//   count         occupancy, $clog2(DEPTH)+1 bits
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A push to a full FIFO is dropped even when a pop frees a slot in the
  // same cycle; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the core data-memory port.
// Registers (ALUResult[3:2]): 0x0 TXDATA (W), 0x4 STATUS (R, W1C OVF),
// 0x8 BAUDDIV (R/W, 16 bits), 0xC reserved. One bit lasts BAUDDIV+1 clocks.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   MemWrite            store strobe
//   ALUResult           byte address
//   WriteData           store data
//   Sel                 combinational window hit
//   ReadData            combinational register read data (0 when !Sel)
//   tx                  serial output, idles high
// Build option: define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] BAUDDIV_RST = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Sel,
  output logic [31:0] ReadData,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [15:0]    timer_q, timer_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic [3:0]     ofs;
  logic           wr_en, push, fifo_pop, fifo_full, fifo_empty, bit_done;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    status;
  logic           unused_bits;

  assign unused_bits = ^{ALUResult[1:0], WriteData[31:16]};

  assign Sel   = (ALUResult[31:4] == BASE_ADDR[31:4]);
  assign ofs   = {ALUResult[3:2], 2'b00};
  assign wr_en = MemWrite && Sel;
  assign push  = wr_en && (ofs == TXDATA_OFS);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                        = '0;
    status[ST_BUSY]               = (state_q != IDLE);
    status[ST_FULL]               = fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_OVF]                = ovf_q;
    status[ST_COUNT_LSB +: 4]     = 4'(fifo_count);
    ReadData = '0;
    if (Sel) begin
      unique case (ofs)
        STATUS_OFS:  ReadData = status;
        BAUDDIV_OFS: ReadData = {16'd0, baud_q};
        default:     ReadData = '0;
      endcase
    end
  end

  // Register writes. A dropped push (FIFO full) latches OVF.
  always_comb begin
    ovf_d  = ovf_q;
    baud_d = baud_q;
    if (push && fifo_full) ovf_d = 1'b1;
    if (wr_en && (ofs == STATUS_OFS) && WriteData[ST_OVF]) ovf_d = 1'b0;
    if (wr_en && (ofs == BAUDDIV_OFS)) baud_d = WriteData[15:0];
  end

  // Transmit FSM. tx is registered; the timer reloads from baud_q at every
  // bit boundary so a new divisor applies from the next bit onward.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    bit_done = (timer_q == 16'd0);
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          timer_d  = baud_q;
          tx_d     = 1'b0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          timer_d = baud_q;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = baud_q;
          shreg_d = shreg_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          timer_d = baud_q;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
        else          timer_d = timer_q - 16'd1;
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      baud_q  <= BAUDDIV_RST;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx = tx_q;

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle RV32I core's data-memory port, alongside data RAM. Decodes the core's store address and write data, queues bytes in a small FIFO, and serialises them as 8N1 frames (optionally 8E1) at a programmable bit rate. Register reads are combinational, so load results return in the same cycle as the core's ALU address.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000: base of the 16-byte register window; bits [3:0] must be zero.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, at least 2.
- BAUDDIV_RST, 16'd867: reset value of BAUDDIV; one bit lasts BAUDDIV+1 clocks.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store strobe from the core.
- ALUResult  input  32  byte address from the core.
- WriteData  input  32  store data from the core.
- Sel  output  1  combinational; high when ALUResult[31:4] == BASE_ADDR[31:4]. The top-level uses it to steer ReadData and gate RAM writes.
- ReadData  output  32  combinational register read data; 0 when Sel is low.
- tx  output  1  serial line; idles high.

## Operation
Register map, decoded from ALUResult[3:2]:
- 0x0 TXDATA (write-only; reads 0):
  - A write with the FIFO not full pushes WriteData[7:0].
  - A write with the FIFO full is dropped and sets OVF.
- 0x4 STATUS (read):
  - bit0 BUSY: FSM not IDLE.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVF, sticky. Writing 1 to bit3 clears it.
  - bits [7:4] COUNT: FIFO occupancy.
  - All other bits read 0.
- 0x8 BAUDDIV (R/W): bits [15:0]; upper bits ignored on write and read 0. A new value takes effect at the next bit boundary.
- 0xC: reserved; writes ignored, reads 0.

FSM states and transitions:
- IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
- START: tx=0 for one bit time.
- DATA: 8 bits, LSB first.
- PARITY: one bit time; only present with the macro (see Configuration).
- STOP: tx=1 for one bit time, then IDLE.

Counters:
- Bit timer counts from BAUDDIV down to 0. It reloads at each bit boundary and is loaded on entry to START.
- A 3-bit data index counts 0..7.

Rules and boundary conditions:
- FULL is judged on the occupancy at the start of the cycle. A push to a full FIFO is dropped even if a pop happens in the same cycle.
- A push and a pop in the same cycle on a non-full, non-empty FIFO leave COUNT unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. COUNT has log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS.
- Asserting reset mid-frame aborts the frame at once: tx=1, FIFO emptied, OVF cleared, BAUDDIV=BAUDDIV_RST.

## Timing
Reset values:
- tx=1, state IDLE, COUNT=0, OVF=0, BAUDDIV=BAUDDIV_RST.
- Sel and ReadData follow the inputs combinationally.

Latency and frame shape:
- A store at edge N makes COUNT visible after edge N.
- The FSM pops at edge N+1; tx falls (START) after edge N+1. From the store to the start bit is 2 clocks.
- Each bit holds for exactly BAUDDIV+1 clocks.
- Frame length is 10×(BAUDDIV+1) clocks, or 11× with parity.
- Back-to-back frames: STOP → IDLE → START costs one extra clock between frames.
- BUSY drops in the IDLE cycle.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is inserted between DATA and STOP.
  - The bit transmitted is even parity: the XOR of the 8 data bits.
- Not defined:
  - No PARITY state exists; frames are 8N1.
  - The parity logic is absent.

## Structure
- Package uart_pkg holds:
  - register offsets TXDATA_OFS, STATUS_OFS, BAUDDIV_OFS;
  - STATUS bit positions;
  - the state enum uart_tx_state_t (IDLE, START, DATA, PARITY, STOP).
- One sub-module, uart_tx_fifo, parameterised by depth and width, with ports:
  - push and pop strobes;
  - din and dout;
  - full and empty flags;
  - count.
- The FSM, bit timer, address decode and read mux live in mmio_uart_tx.

## Test plan
- Reset, then store 0x55 to 0x1000_0000 with BAUDDIV=3:
  - tx=0 for 4 clocks starting 2 clocks after the store;
  - then data bits 1,0,1,0,1,0,1,0, each 4 clocks;
  - then tx=1 for 4 clocks; BUSY=0 afterward.
- Store 0x0000_0001 to BAUDDIV, then 0xA3 to TXDATA: every bit lasts 2 clocks; read of 0x1000_0008 returns 0x0000_0001.
- With the FSM busy, issue 5 stores into a depth-4 FIFO:
  - STATUS reads FULL=1, COUNT=4, OVF=1;
  - a store of 0x8 to STATUS clears OVF;
  - all 4 queued bytes transmit in order.
- Store to 0x1000_0000 at the cycle the FSM pops with COUNT=2: COUNT stays 2; no byte is lost.
- Assert reset mid-DATA: tx=1 immediately; STATUS reads 0x4 (EMPTY only).
- With UART_TX_PARITY_EN, send 0x07: the parity bit is 1 and the frame is 11 bit times; without the macro, 10 bit times.
